// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Revision 1.0 - initial release.
`default_nettype none

package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  OPC_J      = 6'h2;
  localparam logic [5:0]  OPC_RESUME = 6'h3;
  localparam logic [31:0] INST_NOP   = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the jump-decoder links.
// Revision 1.0 - initial release.
`default_nettype none

interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] jmp_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_plus4;
  logic [31:0] resume_addr;

  modport master (
    output imem_req, imem_addr, inst, inst_valid, pc_plus4, resume_addr,
    input  imem_valid, imem_rdata, stall, pc_src, jmp_addr
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_valid, pc_plus4, resume_addr,
    output imem_valid, imem_rdata, stall, pc_src, jmp_addr
  );

endinterface

`default_nettype wire

// File: rtl/if_resume_reg.sv
// Resume-address register: captures pc_plus4 when a J instruction is taken.
// Revision 1.0 - initial release.
`default_nettype none

module if_resume_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        capture_en_i,
  input  wire logic [31:0] pc_plus4_i,
  output logic [31:0]      resume_addr_o
);

  logic [31:0] resume_q;
  logic [31:0] resume_d;

  always_comb begin
    resume_d = resume_q;
    if (capture_en_i) begin
      resume_d = pc_plus4_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resume_q <= RESET_PC;
    end else begin
      resume_q <= resume_d;
    end
  end

  assign resume_addr_o = resume_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC owner, imem req/valid master, feeds jump decode.
// Optional resume register selected by macro IF_RESUME_REG_EN. Revision 1.0.
`default_nettype none

module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  if_fetch_stage_if.master   bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  inst_q, inst_d;
  logic         inst_valid_q, inst_valid_d;
  logic         req_q, req_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_d        = req_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (bus.imem_valid) begin
          inst_d       = bus.imem_rdata;
          inst_valid_d = 1'b1;
          req_d        = 1'b0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          // Request flag is registered so the next fetch issues in the following REQ cycle.
          pc_d         = bus.pc_src ? word_align(bus.jmp_addr) : pc_q + 32'd4;
          pc_plus4_d   = pc_d + 32'd4;
          inst_d       = INST_NOP;
          inst_valid_d = 1'b0;
          req_d        = 1'b1;
          state_d      = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_plus4_q   <= RESET_PC + 32'd4;
      inst_q       <= INST_NOP;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.pc_plus4   = pc_plus4_q;

`ifdef IF_RESUME_REG_EN
  logic capture_en;

  assign capture_en = (state_q == HOLD) && !bus.stall && bus.pc_src
                      && (inst_q[31:26] == OPC_J);

  if_resume_reg #(
    .RESET_PC (RESET_PC)
  ) u_resume_reg (
    .clk           (clk),
    .reset         (reset),
    .capture_en_i  (capture_en),
    .pc_plus4_i    (pc_plus4_q),
    .resume_addr_o (bus.resume_addr)
  );
`else
  assign bus.resume_addr = RESET_PC;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage (memory model driven from one initial block).
// Revision 1.0 - initial release.
`default_nettype none

module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  exp_t        sb_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_resume;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits at negedges for imem_req; returns number of cycles waited.
  task automatic wait_req(output int waited);
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.imem_req !== 1'b1) chk("req_timeout", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic fetch(input int lat, input int stall_cyc, input logic [5:0] op,
                       input logic src, input logic [31:0] jaddr);
    int          w;
    exp_t        e;
    exp_t        got;
    logic [31:0] data;
    wait_req(w);
    data = {op, exp_pc[27:2]};
    chk("req_addr", bus.imem_addr, exp_pc);
    e.inst     = data;
    e.pc_plus4 = exp_pc + 32'd4;
    sb_q.push_back(e);
    for (int i = 0; i < lat; i++) begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("lat_req_held", {31'b0, bus.imem_req}, 32'd1);
      chk("lat_addr_held", bus.imem_addr, exp_pc);
      chk("lat_inst_nop", bus.inst, 32'h0);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    got = sb_q.pop_front();
    chk("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("hold_inst", bus.inst, got.inst);
    chk("hold_pc4", bus.pc_plus4, got.pc_plus4);
    chk("hold_noreq", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < stall_cyc; i++) begin
      bus.stall    = 1'b1;
      bus.pc_src   = 1'b1;
      bus.jmp_addr = 32'h0BAD_0000;
      @(negedge clk);
      chk("stall_inst", bus.inst, got.inst);
      chk("stall_pc4", bus.pc_plus4, got.pc_plus4);
      chk("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("stall_noreq", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.stall    = 1'b0;
    bus.pc_src   = src;
    bus.jmp_addr = jaddr;
`ifdef IF_RESUME_REG_EN
    if (src && op == 6'h2) exp_resume = exp_pc + 32'd4;
`endif
    exp_pc = src ? {jaddr[31:2], 2'b00} : exp_pc + 32'd4;
    @(negedge clk);
    bus.pc_src   = 1'b0;
    bus.jmp_addr = 32'h0;
    chk("next_valid0", {31'b0, bus.inst_valid}, 32'd0);
    chk("next_inst0", bus.inst, 32'h0);
    chk("next_req", {31'b0, bus.imem_req}, 32'd1);
    chk("next_addr", bus.imem_addr, exp_pc);
    chk("next_pc4", bus.pc_plus4, exp_pc + 32'd4);
    chk("resume", bus.resume_addr, exp_resume);
  endtask

  initial begin
    int w;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.jmp_addr   = 32'h0;
    exp_pc     = RESET_PC;
    exp_resume = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_pc4", bus.pc_plus4, RESET_PC + 32'd4);
    chk("rst_resume", bus.resume_addr, RESET_PC);
    reset = 1'b0;
    wait_req(w);
    chk("first_req_lat", w, 32'd1);

    // Zero-wait stream 0,4,8, then latency, stall, jump, wrap.
    fetch(0, 0, 6'h00, 1'b0, 32'h0);
    fetch(0, 0, 6'h08, 1'b0, 32'h0);
    fetch(0, 0, 6'h23, 1'b0, 32'h0);
    fetch(3, 0, 6'h0F, 1'b0, 32'h0);
    fetch(0, 5, 6'h2B, 1'b0, 32'h0);
    fetch(1, 0, 6'h02, 1'b1, 32'h0000_0103);
    fetch(0, 0, 6'h00, 1'b1, 32'hFFFF_FFFF);
    fetch(2, 0, 6'h01, 1'b0, 32'h0);
    fetch(0, 0, 6'h00, 1'b0, 32'h0);

    // Reset in the middle of a request; late valid during IDLE must be dropped.
    wait_req(w);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    exp_pc     = RESET_PC;
    exp_resume = RESET_PC;
    chk("midrst_req0", {31'b0, bus.imem_req}, 32'd0);
    chk("midrst_inst", bus.inst, 32'h0);
    chk("midrst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("midrst_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    bus.imem_valid = 1'b0;
    chk("late_inst", bus.inst, 32'h0);
    chk("late_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("refetch_req", {31'b0, bus.imem_req}, 32'd1);
    chk("refetch_addr", bus.imem_addr, RESET_PC);
    chk("midrst_resume", bus.resume_addr, RESET_PC);
    fetch(0, 0, 6'h04, 1'b0, 32'h0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
